// File: rtl/param_stream_loader_pkg.sv
// -----------------------------------------------------------------------------
// param_stream_loader_pkg
//
// Shared definitions for the parameter stream loader: FSM state encoding,
// default widths, the buffer-select encoding and a small helper that sizes
// the lane counter.
// -----------------------------------------------------------------------------
package param_stream_loader_pkg;

    localparam int DEF_DATA_W = 19;
    localparam int DEF_PACK   = 9;
    localparam int DEF_ADDR_W = 18;

    // Which parameter RAM / local buffer a load targets
    localparam logic SEL_W = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_FLUSH,
        ST_DONE
    } state_t;

    // Width of a counter able to index PACK lanes (at least one bit)
    function automatic int laneWidth(input int pack);
        return (pack > 1) ? $clog2(pack) : 1;
    endfunction

endpackage

// File: rtl/param_stream_loader_lane_packer.sv
// -----------------------------------------------------------------------------
// param_stream_loader_lane_packer
//
// Collects values coming back from the parameter RAM into PACK-lane buffer
// words and produces the registered buffer write strobe, word address and
// data.  Weights fill lanes 0..PACK-1 before a word is written; biases are
// written one per word in lane 0.  A flush writes whatever partial weight
// word is pending with its unfilled lanes zero.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   clear_i      start of a new load: lanes and word address return to 0
//   sel_i        SEL_W = pack weights, SEL_B = one bias per word
//   valid_i      data_i carries a captured RAM value this cycle
//   data_i       RAM value to insert at the current lane
//   flush_i      write the pending partial weight word
//   pending_o    a partial weight word is held (lane counter non-zero)
//   buf_we_o     buffer write strobe (cycle after capture / flush request)
//   buf_addr_o   buffer word address of the current write
//   buf_data_o   packed word, lane 0 in the LSBs
// -----------------------------------------------------------------------------
module param_stream_loader_lane_packer
    import param_stream_loader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int PACK   = DEF_PACK,
    parameter int BUF_AW = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_i,
    input  logic                     sel_i,
    input  logic                     valid_i,
    input  logic [DATA_W-1:0]        data_i,
    input  logic                     flush_i,
    output logic                     pending_o,
    output logic                     buf_we_o,
    output logic [BUF_AW-1:0]        buf_addr_o,
    output logic [PACK*DATA_W-1:0]   buf_data_o
);

    localparam int                WORD_W    = PACK * DATA_W;
    localparam int                LANE_W    = laneWidth(PACK);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK - 1);

    logic [LANE_W-1:0] lane_q, lane_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [BUF_AW-1:0] nextAddr_q, nextAddr_d;
    logic              bufWe_q, bufWe_d;
    logic [BUF_AW-1:0] bufAddr_q, bufAddr_d;
    logic [WORD_W-1:0] bufData_q, bufData_d;

    logic [WORD_W-1:0] merged;
    logic [WORD_W-1:0] biasWord;
    logic              commit;

    // Lane insert and write decision.  The completed word is built from the
    // held lanes plus the value arriving now, so the write goes out on the
    // very next cycle without waiting for the lane register to update.
    always_comb begin
        merged = word_q;
        for (int j = 0; j < PACK; j++) begin
            if (lane_q == LANE_W'(j)) begin
                merged[j*DATA_W +: DATA_W] = data_i;
            end
        end

        biasWord                = '0;
        biasWord[DATA_W-1:0]    = data_i;

        lane_d     = lane_q;
        word_d     = word_q;
        nextAddr_d = nextAddr_q;
        bufWe_d    = 1'b0;
        bufAddr_d  = bufAddr_q;
        bufData_d  = bufData_q;
        commit     = 1'b0;

        if (clear_i) begin
            lane_d     = '0;
            word_d     = '0;
            nextAddr_d = '0;
        end else if (valid_i) begin
            if (sel_i == SEL_B) begin
                bufData_d = biasWord;
                commit    = 1'b1;
            end else if (lane_q == LAST_LANE) begin
                bufData_d = merged;
                commit    = 1'b1;
                lane_d    = '0;
                word_d    = '0;
            end else begin
                word_d = merged;
                lane_d = lane_q + LANE_W'(1);
            end
        end else if (flush_i) begin
            // Unfilled lanes are already zero because lanes clear after each write
            bufData_d = word_q;
            commit    = 1'b1;
            lane_d    = '0;
            word_d    = '0;
        end

        // Buffer address wraps naturally modulo 2^BUF_AW
        if (commit) begin
            bufWe_d    = 1'b1;
            bufAddr_d  = nextAddr_q;
            nextAddr_d = nextAddr_q + BUF_AW'(1);
        end
    end

    // Packer state and registered buffer outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q     <= '0;
            word_q     <= '0;
            nextAddr_q <= '0;
            bufWe_q    <= 1'b0;
            bufAddr_q  <= '0;
            bufData_q  <= '0;
        end else begin
            lane_q     <= lane_d;
            word_q     <= word_d;
            nextAddr_q <= nextAddr_d;
            bufWe_q    <= bufWe_d;
            bufAddr_q  <= bufAddr_d;
            bufData_q  <= bufData_d;
        end
    end

    assign pending_o  = (lane_q != '0);
    assign buf_we_o   = bufWe_q;
    assign buf_addr_o = bufAddr_q;
    assign buf_data_o = bufData_q;

endmodule

// File: rtl/param_stream_loader.sv
// -----------------------------------------------------------------------------
// param_stream_loader
//
// Loads one step's parameter range [firstaddr, lastaddr) from the weight or
// bias RAM into the conv engine's local parameter buffer, packing weights
// PACK to a word, and pulses done when the range has been transferred.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start_i                  one-cycle load request, accepted only when idle
//   re_weights_i, re_bias_i  target RAM (weights win when both are set)
//   firstaddr_i, lastaddr_i  range, first inclusive, last exclusive
//   mem_addr_o               shared RAM read address
//   w_re_o, b_re_o           weight / bias RAM read enables
//   w_data_i, b_data_i       RAM read data, RD_LAT cycles after the address
//   buf_we_o                 buffer write strobe
//   buf_sel_o                0 = weight buffer, 1 = bias buffer
//   buf_addr_o               buffer word address, restarts at 0 per load
//   buf_data_o               packed word, lane 0 in the LSBs
//   busy_o                   load in progress (through the done cycle)
//   done_o                   one-cycle completion pulse
// -----------------------------------------------------------------------------
module param_stream_loader
    import param_stream_loader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int PACK   = DEF_PACK,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int BUF_AW = 12,
    parameter int RD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic                     re_weights_i,
    input  logic                     re_bias_i,
    input  logic [ADDR_W-1:0]        firstaddr_i,
    input  logic [ADDR_W-1:0]        lastaddr_i,
    output logic [ADDR_W-1:0]        mem_addr_o,
    output logic                     w_re_o,
    output logic                     b_re_o,
    input  logic [DATA_W-1:0]        w_data_i,
    input  logic [DATA_W-1:0]        b_data_i,
    output logic                     buf_we_o,
    output logic                     buf_sel_o,
    output logic [BUF_AW-1:0]        buf_addr_o,
    output logic [PACK*DATA_W-1:0]   buf_data_o,
    output logic                     busy_o,
    output logic                     done_o
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] lastAddr_q, lastAddr_d;
    logic              sel_q, sel_d;
    logic [RD_LAT-1:0] validPipe_q, validPipe_d;

    logic              issue;
    logic              capture;
    logic              pipeEmpty;
    logic              pending;
    logic              clearReq;
    logic              flushReq;
    logic [DATA_W-1:0] capData;

    assign issue     = (state_q == ST_READ);
    assign capture   = validPipe_q[RD_LAT-1];
    assign pipeEmpty = (validPipe_q == '0);
    assign capData   = (sel_q == SEL_B) ? b_data_i : w_data_i;

    // Next-state logic.  An empty or untargeted range is sent through a
    // single DRAIN cycle: the pipeline is already empty and no lane is
    // pending, so it falls straight into DONE and done lands two cycles
    // after start without any read being issued.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        lastAddr_d = lastAddr_q;
        sel_d      = sel_q;
        clearReq   = 1'b0;
        flushReq   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    addr_d     = firstaddr_i;
                    lastAddr_d = lastaddr_i;
                    sel_d      = (re_bias_i && !re_weights_i) ? SEL_B : SEL_W;
                    clearReq   = 1'b1;
                    if ((!re_weights_i && !re_bias_i) || (lastaddr_i <= firstaddr_i)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (addr_q == lastAddr_q - ADDR_W'(1)) begin
                    state_d = ST_DRAIN;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            ST_DRAIN: begin
                if (pipeEmpty) begin
                    if (pending) begin
                        flushReq = 1'b1;
                        state_d  = ST_FLUSH;
                    end else begin
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_FLUSH: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read-valid shift register: a one enters with each issued read and
    // reaches the top stage when the RAM data for that read is present.
    always_comb begin
        validPipe_d    = validPipe_q;
        validPipe_d[0] = issue;
        for (int i = 1; i < RD_LAT; i++) begin
            validPipe_d[i] = validPipe_q[i-1];
        end
    end

    // FSM, address counter and valid pipeline registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            lastAddr_q  <= '0;
            sel_q       <= SEL_W;
            validPipe_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            lastAddr_q  <= lastAddr_d;
            sel_q       <= sel_d;
            validPipe_q <= validPipe_d;
        end
    end

    param_stream_loader_lane_packer #(
        .DATA_W (DATA_W),
        .PACK   (PACK),
        .BUF_AW (BUF_AW)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (clearReq),
        .sel_i      (sel_q),
        .valid_i    (capture),
        .data_i     (capData),
        .flush_i    (flushReq),
        .pending_o  (pending),
        .buf_we_o   (buf_we_o),
        .buf_addr_o (buf_addr_o),
        .buf_data_o (buf_data_o)
    );

    assign mem_addr_o = addr_q;
    assign w_re_o     = issue && (sel_q == SEL_W);
    assign b_re_o     = issue && (sel_q == SEL_B);
    assign buf_sel_o  = sel_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = (state_q == ST_DONE);

endmodule

// File: tb/tb_param_stream_loader.sv
// -----------------------------------------------------------------------------
// tb_param_stream_loader
//
// Self-checking bench for param_stream_loader: a table of directed loads,
// randomized loads checked against a behavioural model of the range/packing
// rules, and hand-written sequences for start-while-busy, back-to-back start
// and reset in the middle of a load.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_param_stream_loader;

    localparam int DATA_W      = 19;
    localparam int PACK        = 9;
    localparam int ADDR_W      = 18;
    localparam int BUF_AW      = 12;
    localparam int RD_LAT      = 1;
    localparam int WORD_W      = PACK * DATA_W;
    localparam int LOAD_BUDGET = 400;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                reWeights;
    logic                reBias;
    logic [ADDR_W-1:0]   firstAddr;
    logic [ADDR_W-1:0]   lastAddr;
    logic [ADDR_W-1:0]   memAddr;
    logic                wRe;
    logic                bRe;
    logic [DATA_W-1:0]   wData;
    logic [DATA_W-1:0]   bData;
    logic                bufWe;
    logic                bufSel;
    logic [BUF_AW-1:0]   bufAddr;
    logic [WORD_W-1:0]   bufData;
    logic                busy;
    logic                done;

    param_stream_loader #(
        .DATA_W (DATA_W),
        .PACK   (PACK),
        .ADDR_W (ADDR_W),
        .BUF_AW (BUF_AW),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .re_weights_i (reWeights),
        .re_bias_i    (reBias),
        .firstaddr_i  (firstAddr),
        .lastaddr_i   (lastAddr),
        .mem_addr_o   (memAddr),
        .w_re_o       (wRe),
        .b_re_o       (bRe),
        .w_data_i     (wData),
        .b_data_i     (bData),
        .buf_we_o     (bufWe),
        .buf_sel_o    (bufSel),
        .buf_addr_o   (bufAddr),
        .buf_data_o   (bufData),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    // RAM contents are a fixed function of address, distinct for the two RAMs
    function automatic logic [DATA_W-1:0] ramW(input int a);
        logic [31:0] v;
        v = (a * 37 + 11) ^ 32'h0002_A5C3;
        return v[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] ramB(input int a);
        logic [31:0] v;
        v = (a * 101) + 32'h0001_F00F;
        return v[DATA_W-1:0];
    endfunction

    // Synchronous RAM models with RD_LAT cycles of latency; unread cycles
    // return an all-ones marker so mistimed captures show up in the data.
    logic [DATA_W-1:0] wPipe [RD_LAT];
    logic [DATA_W-1:0] bPipe [RD_LAT];

    always @(posedge clk) begin
        wPipe[0] <= wRe ? ramW(int'(memAddr)) : '1;
        bPipe[0] <= bRe ? ramB(int'(memAddr)) : '1;
        for (int i = 1; i < RD_LAT; i++) begin
            wPipe[i] <= wPipe[i-1];
            bPipe[i] <= bPipe[i-1];
        end
    end

    assign wData = wPipe[RD_LAT-1];
    assign bData = bPipe[RD_LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation of DUT activity for the current load
    typedef struct {
        int                addr;
        bit                sel;
        logic [WORD_W-1:0] data;
        int                cyc;
    } wr_t;

    wr_t writes[$];
    int  rdCount;
    int  rdBad;
    int  rdBadGot;
    int  rdBadExp;
    int  wrongRe;
    int  doneCount;
    int  doneCyc;
    int  expFirst;
    bit  expBias;
    int  startCyc;
    bit  gotDone;

    int  checks = 0;
    int  errors = 0;

    always @(negedge clk) begin
        if (wRe || bRe) begin
            if (int'(memAddr) != expFirst + rdCount && rdBad == 0) begin
                rdBadGot = int'(memAddr);
                rdBadExp = expFirst + rdCount;
            end
            if (int'(memAddr) != expFirst + rdCount) rdBad++;
            if ((wRe && bRe) || (wRe && expBias) || (bRe && !expBias)) wrongRe++;
            rdCount++;
        end
        if (bufWe) begin
            writes.push_back('{addr: int'(bufAddr), sel: bufSel, data: bufData, cyc: cyc});
        end
        if (done) begin
            doneCount++;
            doneCyc = cyc;
        end
    end

    task automatic checkOutput(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic checkWord(input string name, input logic [WORD_W-1:0] got,
                             input logic [WORD_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic clearMonitor();
        writes.delete();
        rdCount   = 0;
        rdBad     = 0;
        wrongRe   = 0;
        doneCount = 0;
    endtask

    // Behavioural reference: which values end up in buffer word idx
    function automatic logic [WORD_W-1:0] modelWord(input int first, input int last,
                                                    input bit bias, input int idx);
        logic [WORD_W-1:0] w;
        w = '0;
        if (bias) begin
            w[DATA_W-1:0] = ramB(first + idx);
        end else begin
            for (int j = 0; j < PACK; j++) begin
                if (first + idx * PACK + j < last) begin
                    w[j*DATA_W +: DATA_W] = ramW(first + idx * PACK + j);
                end
            end
        end
        return w;
    endfunction

    function automatic int modelReads(input int first, input int last, input bit rw, input bit rb);
        return ((rw || rb) && last > first) ? last - first : 0;
    endfunction

    function automatic int modelWrites(input int n, input bit bias);
        return bias ? n : (n + PACK - 1) / PACK;
    endfunction

    // Done latency from the start cycle: reads take N cycles, data returns
    // RD_LAT later, the write follows a cycle after capture and done a cycle
    // after the last write; a partial word costs one extra flush cycle.
    function automatic int modelDoneLat(input int n, input bit bias);
        if (n == 0) return 2;
        if (bias || (n % PACK) == 0) return n + RD_LAT + 2;
        return n + RD_LAT + 3;
    endfunction

    // Issue one load and wait (bounded) for its done pulse.  injectAt > 0
    // pulses start with a different range that many cycles into the load.
    task automatic applyStimulus(input int first, input int last, input bit rw,
                                 input bit rb, input int injectAt);
        @(posedge clk);
        #1;
        clearMonitor();
        expFirst  = first;
        expBias   = rb && !rw;
        firstAddr = ADDR_W'(first);
        lastAddr  = ADDR_W'(last);
        reWeights = rw;
        reBias    = rb;
        start     = 1'b1;
        startCyc  = cyc;
        @(posedge clk);
        #1;
        start   = 1'b0;
        gotDone = 1'b0;
        for (int i = 0; i < LOAD_BUDGET && !gotDone; i++) begin
            @(negedge clk);
            #1;
            if (injectAt > 0 && cyc == startCyc + injectAt) begin
                start     = 1'b1;
                firstAddr = ADDR_W'(7);
                lastAddr  = ADDR_W'(9);
                reWeights = 1'b0;
                reBias    = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (doneCount > 0) gotDone = 1'b1;
        end
        start = 1'b0;
        checkOutput("doneSeen", gotDone, 1);
    endtask

    task automatic verifyLoad(input int first, input int last, input bit rw, input bit rb,
                              input int expReads, input int expWrites, input int expDone);
        bit bias;
        bias = rb && !rw;
        checkOutput("doneLatency", doneCyc - startCyc, expDone);
        checkOutput("doneCount", doneCount, 1);
        checkOutput("readCount", rdCount, expReads);
        if (rdBad != 0) $display("[TB] first bad read address %0d, wanted %0d", rdBadGot, rdBadExp);
        checkOutput("readAddrErrors", rdBad, 0);
        checkOutput("readEnableKind", wrongRe, 0);
        checkOutput("writeCount", writes.size(), expWrites);
        foreach (writes[i]) begin
            checkOutput($sformatf("writeAddr[%0d]", i), writes[i].addr, i % (1 << BUF_AW));
            checkOutput($sformatf("writeSel[%0d]", i), writes[i].sel, bias);
            checkWord($sformatf("writeData[%0d]", i), writes[i].data, modelWord(first, last, bias, i));
        end
        if (writes.size() > 0) begin
            checkOutput("lastWriteToDone", doneCyc - writes[writes.size()-1].cyc, 1);
        end
    endtask

    typedef struct {
        int first;
        int last;
        bit rw;
        bit rb;
        int expReads;
        int expWrites;
        int expDone;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // first, last, re_weights, re_bias, reads, writes, done latency
        vecs[0] = '{0,   216, 1'b1, 1'b0, 216, 24, 219};
        vecs[1] = '{0,   8,   1'b0, 1'b1, 8,   8,  11};
        vecs[2] = '{10,  14,  1'b1, 1'b0, 4,   1,  8};
        vecs[3] = '{5,   5,   1'b1, 1'b0, 0,   0,  2};
        vecs[4] = '{0,   10,  1'b0, 1'b0, 0,   0,  2};
        vecs[5] = '{3,   12,  1'b1, 1'b1, 9,   1,  12};
        vecs[6] = '{20,  10,  1'b0, 1'b1, 0,   0,  2};

        rst       = 1'b1;
        start     = 1'b0;
        reWeights = 1'b0;
        reBias    = 1'b0;
        firstAddr = '0;
        lastAddr  = '0;
        clearMonitor();
        expFirst  = 0;
        expBias   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetBusy", busy, 0);
        checkOutput("resetDone", done, 0);
        checkOutput("resetWre", wRe, 0);
        checkOutput("resetBre", bRe, 0);
        checkOutput("resetBufWe", bufWe, 0);
        checkOutput("resetMemAddr", memAddr, 0);
        checkOutput("resetBufAddr", bufAddr, 0);
        checkOutput("resetBufSel", bufSel, 0);
        checkWord("resetBufData", bufData, '0);
        rst = 1'b0;

        $display("[TB] directed table");
        for (int v = 0; v < 7; v++) begin
            applyStimulus(vecs[v].first, vecs[v].last, vecs[v].rw, vecs[v].rb, 0);
            verifyLoad(vecs[v].first, vecs[v].last, vecs[v].rw, vecs[v].rb,
                       vecs[v].expReads, vecs[v].expWrites, vecs[v].expDone);
        end

        $display("[TB] start during READ, then back-to-back start");
        applyStimulus(0, 216, 1'b1, 1'b0, 50);
        verifyLoad(0, 216, 1'b1, 1'b0, 216, 24, 219);
        applyStimulus(10, 14, 1'b1, 1'b0, 0);
        checkOutput("backToBackStartCycle", startCyc, doneCyc - 8 + 0);
        verifyLoad(10, 14, 1'b1, 1'b0, 4, 1, 8);

        $display("[TB] randomized loads");
        for (int r = 0; r < 14; r++) begin
            int first, last, n;
            bit rw, rb, bias;
            first = int'($urandom_range(0, 3000));
            last  = first + int'($urandom_range(0, 40));
            if ($urandom_range(0, 5) == 0) last = first - int'($urandom_range(1, 5));
            if (last < 0) last = 0;
            rw    = 1'($urandom_range(0, 1));
            rb    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0 && !rw && !rb) rb = 1'b1;
            bias  = rb && !rw;
            n     = modelReads(first, last, rw, rb);
            applyStimulus(first, last, rw, rb, 0);
            verifyLoad(first, last, rw, rb, n, modelWrites(n, bias), modelDoneLat(n, bias));
        end

        $display("[TB] reset during a weight load");
        @(posedge clk);
        #1;
        clearMonitor();
        expFirst  = 0;
        expBias   = 1'b0;
        firstAddr = ADDR_W'(0);
        lastAddr  = ADDR_W'(216);
        reWeights = 1'b1;
        reBias    = 1'b0;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < LOAD_BUDGET && rdCount < 101; i++) begin
            @(negedge clk);
            #1;
        end
        checkOutput("rstReachedRead100", rdCount, 101);
        rst = 1'b1;
        #1;
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstWre", wRe, 0);
        checkOutput("rstMemAddr", memAddr, 0);
        checkOutput("rstBufWe", bufWe, 0);
        checkOutput("rstBufAddr", bufAddr, 0);
        checkWord("rstBufData", bufData, '0);
        clearMonitor();
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        checkOutput("rstNoDone", doneCount, 0);
        checkOutput("rstNoWrites", writes.size(), 0);
        checkOutput("rstNoReads", rdCount, 0);
        applyStimulus(0, 216, 1'b1, 1'b0, 0);
        verifyLoad(0, 216, 1'b1, 1'b0, 216, 24, 219);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
